// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

   localparam int WORD_W = 16;

   localparam logic [3:0]        DEF_HLT_OP    = 4'hF;
   localparam logic [WORD_W-1:0] DEF_NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc_plus2;
      logic              valid;
   } if_id_t;

   function automatic logic is_hlt(input logic [WORD_W-1:0] instr, input logic [3:0] op);
      return instr[WORD_W-1 -: 4] == op;
   endfunction

endpackage

// File: rtl/adder_pc.sv
// PC incrementer: modulo-2^WORD_W sum used for the sequential fetch address.
module adder_pc
   import if_stage_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, multi-cycle imem handshake, IF/ID register,
// one-entry hold buffer for stalls, redirect draining and HLT stop.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
   parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
   parameter logic [3:0]        HLT_OP    = DEF_HLT_OP
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              imem_ready,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [WORD_W-1:0] redirect_pc_i,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] if_id_instr,
   output logic [WORD_W-1:0] if_id_pc_plus2,
   output logic              if_id_valid,
   output logic              fetch_halted
);

   fetch_state_t      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d, pc_plus2;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic [WORD_W-1:0] pend_q, pend_d;
   if_id_t            ifid_q, ifid_d;
   logic              halted_q, halted_d;
   logic              accept;
   logic [WORD_W-1:0] accept_instr;

   adder_pc u_adder_pc (
      .a   (pc_q),
      .b   (WORD_W'(2)),
      .sum (pc_plus2)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      pend_d       = pend_q;
      ifid_d       = ifid_q;
      halted_d     = halted_q;
      accept       = 1'b0;
      accept_instr = imem_rdata;

      case (state_q)
         FETCH: begin
            if (redirect_i) begin
               ifid_d = '{instr: NOP_INSTR, pc_plus2: ifid_q.pc_plus2, valid: 1'b0};
               if (imem_ready) begin
                  pc_d = redirect_pc_i;
               end else begin
                  // Outstanding request cannot be cancelled; wait for it to retire.
                  pend_d  = redirect_pc_i;
                  state_d = DRAIN;
               end
            end else if (imem_ready && stall_i) begin
               hold_d  = imem_rdata;
               state_d = HOLD;
            end else if (imem_ready) begin
               accept = 1'b1;
            end else if (!stall_i) begin
               ifid_d = '{instr: NOP_INSTR, pc_plus2: ifid_q.pc_plus2, valid: 1'b0};
            end
         end
         HOLD: begin
            if (redirect_i) begin
               ifid_d  = '{instr: NOP_INSTR, pc_plus2: ifid_q.pc_plus2, valid: 1'b0};
               pc_d    = redirect_pc_i;
               state_d = FETCH;
            end else if (!stall_i) begin
               accept       = 1'b1;
               accept_instr = hold_q;
            end
         end
         DRAIN: begin
            ifid_d = '{instr: NOP_INSTR, pc_plus2: ifid_q.pc_plus2, valid: 1'b0};
            if (redirect_i) pend_d = redirect_pc_i;
            if (imem_ready) begin
               pc_d    = redirect_i ? redirect_pc_i : pend_q;
               state_d = FETCH;
            end
         end
         HALTED: begin
            if (redirect_i) begin
               ifid_d   = '{instr: NOP_INSTR, pc_plus2: ifid_q.pc_plus2, valid: 1'b0};
               pc_d     = redirect_pc_i;
               halted_d = 1'b0;
               state_d  = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (accept) begin
         ifid_d = '{instr: accept_instr, pc_plus2: pc_plus2, valid: 1'b1};
         if (is_hlt(accept_instr, HLT_OP)) begin
            halted_d = 1'b1;
            state_d  = HALTED;
         end else begin
            pc_d    = pc_plus2;
            state_d = FETCH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         hold_q   <= '0;
         pend_q   <= '0;
         ifid_q   <= '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         hold_q   <= hold_d;
         pend_q   <= pend_d;
         ifid_q   <= ifid_d;
         halted_q <= halted_d;
      end
   end

   // Gated by rst_n so no request is visible while reset is held.
   assign imem_req       = rst_n && (state_q == FETCH || state_q == DRAIN);
   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign if_id_instr    = ifid_q.instr;
   assign if_id_pc_plus2 = ifid_q.pc_plus2;
   assign if_id_valid    = ifid_q.valid;
   assign fetch_halted   = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset sequence, then randomized
// memory latency / stall / redirect traffic against a flag-based behavioural model.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic        stall_i;
   logic        redirect_i;
   logic [15:0] redirect_pc_i;
   logic [15:0] pc;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus2;
   logic        if_id_valid;
   logic        fetch_halted;

   int checks   = 0;
   int failures = 0;

   if_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .stall_i        (stall_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .pc             (pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus2 (if_id_pc_plus2),
      .if_id_valid    (if_id_valid),
      .fetch_halted   (fetch_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic [15:0] rdata;
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic [15:0] e_pc;
      logic [15:0] e_instr;
      logic [15:0] e_pp2;
      logic        e_valid;
      logic        e_halt;
      logic        e_req;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic rdy, input logic [15:0] rdata, input logic stall,
                               input logic redir, input logic [15:0] rpc, input logic [15:0] e_pc,
                               input logic [15:0] e_instr, input logic [15:0] e_pp2,
                               input logic e_valid, input logic e_halt, input logic e_req);
      vec_t v;
      v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.redir = redir; v.rpc = rpc;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp2 = e_pp2;
      v.e_valid = e_valid; v.e_halt = e_halt; v.e_req = e_req;
      return v;
   endfunction

   // Reference model: the stage seen as "halted / draining / holding a word / fetching".
   logic [15:0] m_pc, m_instr, m_pp2, m_buf, m_target;
   logic        m_valid, m_halted, m_has_buf, m_drain;

   task automatic m_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
      m_halted = 1'b0; m_has_buf = 1'b0; m_drain = 1'b0; m_buf = '0; m_target = '0;
   endtask

   task automatic m_flush();
      m_instr = 16'h0000;
      m_valid = 1'b0;
   endtask

   task automatic m_take(input logic [15:0] w);
      m_instr = w;
      m_pp2   = m_pc + 16'd2;
      m_valid = 1'b1;
      if (w[15:12] == 4'hF) m_halted = 1'b1;
      else                  m_pc = m_pc + 16'd2;
   endtask

   task automatic m_step(input logic rdy, input logic [15:0] rdata, input logic stall,
                         input logic redir, input logic [15:0] rpc);
      if (m_halted) begin
         if (redir) begin m_flush(); m_halted = 1'b0; m_pc = rpc; end
      end else if (m_drain) begin
         m_flush();
         if (redir) m_target = rpc;
         if (rdy) begin m_pc = m_target; m_drain = 1'b0; end
      end else if (m_has_buf) begin
         if (redir) begin m_flush(); m_has_buf = 1'b0; m_pc = rpc; end
         else if (!stall) begin m_has_buf = 1'b0; m_take(m_buf); end
      end else begin
         if (redir) begin
            m_flush();
            if (rdy) m_pc = rpc;
            else begin m_drain = 1'b1; m_target = rpc; end
         end else if (rdy && stall) begin
            m_has_buf = 1'b1; m_buf = rdata;
         end else if (rdy) begin
            m_take(rdata);
         end else if (!stall) begin
            m_flush();
         end
      end
   endtask

   function automatic logic [15:0] memw(input logic [15:0] a);
      logic [31:0] t;
      t = {16'h0, a} * 32'h0000_9E37 + 32'h0000_1234;
      return t[23:8];
   endfunction

   int          wcnt;
   int          lat;
   logic        exp_req;
   logic        rdy;
   logic        st;
   logic        rd;
   logic [15:0] rp;
   logic [15:0] w;

   initial begin
      rst_n = 1'b0; imem_rdata = '0; imem_ready = 1'b0;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

      vt.push_back(mk(1, 16'h1123, 0, 0, 16'h0,    16'h0002, 16'h1123, 16'h0002, 1, 0, 1));
      vt.push_back(mk(1, 16'h2345, 0, 0, 16'h0,    16'h0004, 16'h2345, 16'h0004, 1, 0, 1));
      vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    16'h0004, 16'h0000, 16'h0004, 0, 0, 1));
      vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    16'h0004, 16'h0000, 16'h0004, 0, 0, 1));
      vt.push_back(mk(1, 16'h3456, 0, 0, 16'h0,    16'h0006, 16'h3456, 16'h0006, 1, 0, 1));
      vt.push_back(mk(1, 16'h7777, 0, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0006, 0, 0, 1));
      vt.push_back(mk(1, 16'hA456, 1, 0, 16'h0,    16'h0010, 16'h0000, 16'h0006, 0, 0, 0));
      vt.push_back(mk(0, 16'h0,    1, 0, 16'h0,    16'h0010, 16'h0000, 16'h0006, 0, 0, 0));
      vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    16'h0012, 16'hA456, 16'h0012, 1, 0, 1));
      vt.push_back(mk(0, 16'h0,    0, 1, 16'h0040, 16'h0012, 16'h0000, 16'h0012, 0, 0, 1));
      vt.push_back(mk(0, 16'h0,    0, 1, 16'h0080, 16'h0012, 16'h0000, 16'h0012, 0, 0, 1));
      vt.push_back(mk(0, 16'h0,    1, 0, 16'h0,    16'h0012, 16'h0000, 16'h0012, 0, 0, 1));
      vt.push_back(mk(1, 16'h1111, 0, 0, 16'h0,    16'h0080, 16'h0000, 16'h0012, 0, 0, 1));
      vt.push_back(mk(1, 16'h2222, 0, 1, 16'h0008, 16'h0008, 16'h0000, 16'h0012, 0, 0, 1));
      vt.push_back(mk(1, 16'hF000, 0, 0, 16'h0,    16'h0008, 16'hF000, 16'h000A, 1, 1, 0));
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(0, 16'h0, (i % 2), 0, 16'h0, 16'h0008, 16'hF000, 16'h000A, 1, 1, 0));
      vt.push_back(mk(0, 16'h0,    1, 1, 16'h0020, 16'h0020, 16'h0000, 16'h000A, 0, 0, 1));
      vt.push_back(mk(1, 16'h3333, 0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h000A, 0, 0, 1));
      vt.push_back(mk(1, 16'h1234, 0, 0, 16'h0,    16'h0000, 16'h1234, 16'h0000, 1, 0, 1));
      vt.push_back(mk(1, 16'h4444, 1, 1, 16'h0030, 16'h0030, 16'h0000, 16'h0000, 0, 0, 1));
      vt.push_back(mk(1, 16'hF123, 1, 0, 16'h0,    16'h0030, 16'h0000, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 16'h0,    0, 0, 16'h0,    16'h0030, 16'hF123, 16'h0032, 1, 1, 0));
      vt.push_back(mk(0, 16'h0,    0, 1, 16'h0050, 16'h0050, 16'h0000, 16'h0032, 0, 0, 1));
      vt.push_back(mk(1, 16'h5555, 1, 0, 16'h0,    16'h0050, 16'h0000, 16'h0032, 0, 0, 0));
      vt.push_back(mk(0, 16'h0,    1, 1, 16'h0060, 16'h0060, 16'h0000, 16'h0032, 0, 0, 1));
      vt.push_back(mk(1, 16'h6666, 1, 0, 16'h0,    16'h0060, 16'h0000, 16'h0032, 0, 0, 0));

      #1;
      chk("rst_req",   imem_req,       1'b0);
      chk("rst_pc",    pc,             16'h0000);
      chk("rst_instr", if_id_instr,    16'h0000);
      chk("rst_pp2",   if_id_pc_plus2, 16'h0000);
      chk("rst_valid", if_id_valid,    1'b0);
      chk("rst_halt",  fetch_halted,   1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_req", imem_req, 1'b1);

      foreach (vt[i]) begin
         imem_ready = vt[i].rdy; imem_rdata = vt[i].rdata; stall_i = vt[i].stall;
         redirect_i = vt[i].redir; redirect_pc_i = vt[i].rpc;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pc", i),    pc,             vt[i].e_pc);
         chk($sformatf("vec%0d_addr", i),  imem_addr,      vt[i].e_pc);
         chk($sformatf("vec%0d_instr", i), if_id_instr,    vt[i].e_instr);
         chk($sformatf("vec%0d_pp2", i),   if_id_pc_plus2, vt[i].e_pp2);
         chk($sformatf("vec%0d_valid", i), if_id_valid,    vt[i].e_valid);
         chk($sformatf("vec%0d_halt", i),  fetch_halted,   vt[i].e_halt);
         chk($sformatf("vec%0d_req", i),   imem_req,       vt[i].e_req);
         @(negedge clk);
      end

      // Stage is in HOLD now; pull reset away from any clock edge.
      imem_ready = 1'b0; stall_i = 1'b1; redirect_i = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_req",   imem_req,       1'b0);
      chk("arst_pc",    pc,             16'h0000);
      chk("arst_instr", if_id_instr,    16'h0000);
      chk("arst_pp2",   if_id_pc_plus2, 16'h0000);
      chk("arst_valid", if_id_valid,    1'b0);
      chk("arst_halt",  fetch_halted,   1'b0);
      stall_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("arst_held_req", imem_req, 1'b0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk("arst_rel_req",  imem_req,  1'b1);
      chk("arst_rel_addr", imem_addr, 16'h0000);

      m_reset();
      wcnt = 0;
      lat  = $urandom_range(0, 3);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         exp_req = !m_halted && !m_has_buf;
         chk("rnd_req", imem_req, exp_req);
         if (exp_req) chk("rnd_addr", imem_addr, m_pc);
         rdy = imem_req && (wcnt >= lat);
         w   = rdy ? memw(imem_addr) : 16'($urandom);
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         rp  = 16'($urandom_range(0, 32767) * 2);
         imem_ready = rdy; imem_rdata = w; stall_i = st; redirect_i = rd; redirect_pc_i = rp;
         m_step(rdy, w, st, rd, rp);
         @(posedge clk); #1;
         chk("rnd_pc",    pc,             m_pc);
         chk("rnd_instr", if_id_instr,    m_instr);
         chk("rnd_valid", if_id_valid,    m_valid);
         if (m_valid) chk("rnd_pp2", if_id_pc_plus2, m_pp2);
         chk("rnd_halt",  fetch_halted,   m_halted);
         if (rdy) begin
            wcnt = 0;
            lat  = $urandom_range(0, 3);
         end else if (imem_req) begin
            wcnt++;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
